// File: rtl/uart_pkg.sv
// Purpose: shared types and frame constants for the UART receive-to-memory path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   localparam int   FRAME_DATA_BITS = 8;
   localparam logic START_BIT       = 1'b0;
   localparam logic STOP_BIT        = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose: two-flop synchroniser bringing the asynchronous rx line into clk.
// Latency: 2 clk from rx to rx_s.
// Backpressure: none; free-running.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values: shift the line one stage per clock.
   always_comb begin
      meta_d = rx;
      sync_d = meta_q;
   end

   // Both stages reset to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign rx_s = sync_q;

endmodule

// File: rtl/uart_rx_mem_writer.sv
// Purpose: 8N1 UART receiver writing each byte to consecutive memory addresses, done/full at DEPTH.
// Latency: we ~ 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk after the start-bit falling edge.
// Backpressure: none; writes are one-cycle strobes, line activity is ignored while full.
module uart_rx_mem_writer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int DEPTH        = 1024,
   parameter int ADDR_W       = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   input  logic              clear,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        data,
   output logic              we,
   output logic              busy,
   output logic              frame_err,
   output logic              done,
   output logic              full
);

   localparam int SC_W = $clog2(CLKS_PER_BIT);
   localparam int BC_W = $clog2(FRAME_DATA_BITS);

   localparam logic [SC_W-1:0]   SC_MID    = SC_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(CLKS_PER_BIT - 1);
   localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(FRAME_DATA_BITS - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic rx_s;

   state_t                     state_q, state_d;
   logic [SC_W-1:0]            sc_q, sc_d;
   logic [BC_W-1:0]            bc_q, bc_d;
   logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
   logic [ADDR_W-1:0]          wptr_q, wptr_d;
   logic [ADDR_W-1:0]          addr_q, addr_d;
   logic [7:0]                 data_q, data_d;
   logic                       we_q, we_d;
   logic                       frame_err_q, frame_err_d;
   logic                       done_q, done_d;
   logic                       full_q, full_d;

   uart_rx_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .rx   (rx),
      .rx_s (rx_s)
   );

   // Frame FSM: mid-bit sampling, write pointer advance, and clear override.
   always_comb begin
      state_d     = state_q;
      sc_d        = sc_q;
      bc_d        = bc_q;
      shift_d     = shift_q;
      wptr_d      = wptr_q;
      addr_d      = addr_q;
      data_d      = data_q;
      we_d        = 1'b0;
      frame_err_d = 1'b0;
      done_d      = 1'b0;
      full_d      = full_q;

      case (state_q)
         IDLE: begin
            if (rx_s == START_BIT && !full_q) begin
               state_d = START;
               sc_d    = '0;
            end
         end
         START: begin
            if (sc_q == SC_MID) begin
               if (rx_s == START_BIT) begin
                  sc_d    = '0;
                  bc_d    = '0;
                  state_d = DATA;
               end else begin
                  // Start bit did not survive to mid-bit: treat as a glitch.
                  state_d = IDLE;
               end
            end else begin
               sc_d = sc_q + 1'b1;
            end
         end
         DATA: begin
            if (sc_q == SC_LAST) begin
               shift_d = {rx_s, shift_q[FRAME_DATA_BITS-1:1]};
               bc_d    = bc_q + 1'b1;
               sc_d    = '0;
               if (bc_q == BC_LAST) begin
                  state_d = STOP;
               end
            end else begin
               sc_d = sc_q + 1'b1;
            end
         end
         STOP: begin
            if (sc_q == SC_LAST) begin
               sc_d = '0;
               if (rx_s == STOP_BIT) begin
                  data_d  = shift_q;
                  addr_d  = wptr_q;
                  we_d    = 1'b1;
                  state_d = IDLE;
                  if (wptr_q == LAST_ADDR) begin
                     // Last slot of the block: pointer parks here until clear.
                     done_d = 1'b1;
                     full_d = 1'b1;
                  end else begin
                     wptr_d = wptr_q + 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end else begin
               sc_d = sc_q + 1'b1;
            end
         end
         BREAK: begin
            // Hold off until the line returns high so a stuck-low line cannot retrigger.
            if (rx_s == STOP_BIT) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Clear aborts everything, including a write landing on the same cycle.
      if (clear) begin
         state_d     = IDLE;
         sc_d        = '0;
         bc_d        = '0;
         wptr_d      = '0;
         full_d      = 1'b0;
         addr_d      = addr_q;
         data_d      = data_q;
         we_d        = 1'b0;
         done_d      = 1'b0;
         frame_err_d = 1'b0;
      end
   end

   // State and output registers; reset dominates clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sc_q        <= '0;
         bc_q        <= '0;
         shift_q     <= '0;
         wptr_q      <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         we_q        <= 1'b0;
         frame_err_q <= 1'b0;
         done_q      <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sc_q        <= sc_d;
         bc_q        <= bc_d;
         shift_q     <= shift_d;
         wptr_q      <= wptr_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         we_q        <= we_d;
         frame_err_q <= frame_err_d;
         done_q      <= done_d;
         full_q      <= full_d;
      end
   end

   assign addr      = addr_q;
   assign data      = data_q;
   assign we        = we_q;
   assign busy      = (state_q != IDLE);
   assign frame_err = frame_err_q;
   assign done      = done_q;
   assign full      = full_q;

endmodule

// File: tb/tb_uart_rx_mem_writer.sv
// Purpose: scoreboard bench for uart_rx_mem_writer with directed serial frames.
// Latency: expected write strobe ~79 clk after start edge at 8 clk/bit.
// Backpressure: n/a; the monitor consumes every strobe as it appears.
module tb_uart_rx_mem_writer;

   localparam int CPB    = 8;
   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;

   logic              clk;
   logic              rst;
   logic              rx;
   logic              clear;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        data;
   logic              we;
   logic              busy;
   logic              frame_err;
   logic              done;
   logic              full;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      logic              done;
      logic              full;
      int                gap;
      bit                lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   fall_cyc = 0;
   int   last_we  = 0;
   int   ferr_seen = 0;

   uart_rx_mem_writer #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH),
      .ADDR_W       (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .clear     (clear),
      .addr      (addr),
      .data      (data),
      .we        (we),
      .busy      (busy),
      .frame_err (frame_err),
      .done      (done),
      .full      (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) ferr_seen++;
         if (done && !we) begin
            checks++;
            errors++;
            $display("FAIL done_without_we got done=1 we=0 expected done only with we");
         end
         if (we) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_we got addr=%0d data=%0h expected no write", addr, data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("we_addr", 32'(addr), 32'(e.addr));
               check("we_data", 32'(data), 32'(e.data));
               check("we_done", 32'(done), 32'(e.done));
               check("we_full", 32'(full), 32'(e.full));
               check("we_busy", 32'(busy), 32'(0));
               if (e.gap > 0) check("we_gap", 32'(cyc - last_we), 32'(e.gap));
               if (e.lat) begin
                  checks++;
                  if ((cyc - fall_cyc) < 78 || (cyc - fall_cyc) > 80) begin
                     errors++;
                     $display("FAIL we_latency got %0d expected 78..80", cyc - fall_cyc);
                  end
               end
            end
            last_we = cyc;
         end
      end
   end

   task automatic push(input int a, input int d, input logic dn, input logic fl, input int gap, input bit lat);
      exp_t e;
      e.addr = ADDR_W'(a);
      e.data = 8'(d);
      e.done = dn;
      e.full = fl;
      e.gap  = gap;
      e.lat  = lat;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      idle(4);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_addr"},      32'(addr),      32'(0));
      check({tag, "_data"},      32'(data),      32'(0));
      check({tag, "_we"},        32'(we),        32'(0));
      check({tag, "_busy"},      32'(busy),      32'(0));
      check({tag, "_frame_err"}, 32'(frame_err), 32'(0));
      check({tag, "_done"},      32'(done),      32'(0));
      check({tag, "_full"},      32'(full),      32'(0));
   endtask

   // One 10-bit frame; abort_bit >= 0 pulses clear (or rst) mid-way through that bit.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit, input bit use_rst);
      for (int i = 0; i < 10; i++) begin
         rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
         if (i == 0) fall_cyc = cyc;
         for (int c = 0; c < CPB; c++) begin
            if (i == abort_bit && c == 3) begin
               if (use_rst) rst = 1'b1;
               else clear = 1'b1;
            end else if (i == abort_bit && c == 4) begin
               if (use_rst) begin
                  check_outputs_zero("midframe_rst");
                  rst = 1'b0;
               end else begin
                  clear = 1'b0;
               end
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({name, "_pending"}, 32'(exp_q.size()), 32'(0));
      exp_q.delete();
   endtask

   initial begin
      rx    = 1'b1;
      clear = 1'b0;
      rst   = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      idle(5);

      // Single frame with latency check and hold-after-write.
      push(0, 8'hA5, 1'b0, 1'b0, 0, 1'b1);
      send_frame(8'hA5, 1'b1, -1, 1'b0);
      idle(20);
      wait_drain("single");
      check("single_ferr", 32'(ferr_seen), 32'(0));
      check("single_hold_data", 32'(data), 32'h A5);
      check("single_hold_addr", 32'(addr), 32'(0));
      check("single_busy", 32'(busy), 32'(0));

      // Back-to-back frames, 80 clk strobe spacing.
      pulse_clear();
      push(0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      push(1, 8'hFF, 1'b0, 1'b0, 80, 1'b0);
      push(2, 8'h3C, 1'b0, 1'b0, 80, 1'b0);
      send_frame(8'h00, 1'b1, -1, 1'b0);
      send_frame(8'hFF, 1'b1, -1, 1'b0);
      send_frame(8'h3C, 1'b1, -1, 1'b0);
      idle(20);
      wait_drain("b2b");

      // Glitch shorter than half a bit.
      pulse_clear();
      rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(20);
      check("glitch_busy", 32'(busy), 32'(0));
      push(0, 8'h12, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h12, 1'b1, -1, 1'b0);
      idle(20);
      wait_drain("glitch");
      check("glitch_ferr", 32'(ferr_seen), 32'(0));

      // Framing error followed by a long low line.
      pulse_clear();
      send_frame(8'h55, 1'b0, -1, 1'b0);
      rx = 1'b0;
      repeat (40) @(negedge clk);
      check("break_busy_low", 32'(busy), 32'(1));
      idle(20);
      check("ferr_count", 32'(ferr_seen), 32'(1));
      check("ferr_busy", 32'(busy), 32'(0));
      push(0, 8'h66, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h66, 1'b1, -1, 1'b0);
      idle(20);
      wait_drain("after_ferr");
      check("ferr_count_final", 32'(ferr_seen), 32'(1));

      // Full block, then one extra byte that must be ignored.
      pulse_clear();
      for (int i = 0; i < DEPTH; i++) begin
         push(i, i % 256, (i == DEPTH - 1), (i == DEPTH - 1), (i > 0) ? 80 : 0, 1'b0);
      end
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(8'(i % 256), 1'b1, -1, 1'b0);
      end
      idle(20);
      wait_drain("full_block");
      check("full_set", 32'(full), 32'(1));
      send_frame(8'hAB, 1'b1, -1, 1'b0);
      idle(20);
      check("full_still", 32'(full), 32'(1));
      check("full_ignored_addr", 32'(addr), 32'(DEPTH - 1));
      check("full_ignored_data", 32'(data), 32'hFF);
      check("full_busy", 32'(busy), 32'(0));

      // Clear mid-frame.
      pulse_clear();
      check("clear_full", 32'(full), 32'(0));
      push(0, 8'h11, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h11, 1'b1, -1, 1'b0);
      idle(20);
      wait_drain("pre_clear");
      send_frame(8'hF0, 1'b1, 5, 1'b0);
      idle(20);
      check("clear_abort_addr", 32'(addr), 32'(0));
      check("clear_abort_data", 32'(data), 32'h11);
      push(0, 8'h77, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h77, 1'b1, -1, 1'b0);
      idle(20);
      wait_drain("after_clear");
      check("after_clear_full", 32'(full), 32'(0));

      // Reset mid-frame.
      push(1, 8'h22, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h22, 1'b1, -1, 1'b0);
      idle(20);
      wait_drain("pre_rst");
      send_frame(8'hF0, 1'b1, 5, 1'b1);
      idle(20);
      push(0, 8'h33, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h33, 1'b1, -1, 1'b0);
      idle(20);
      wait_drain("after_rst");
      check("final_ferr", 32'(ferr_seen), 32'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #990000;
      checks++;
      errors++;
      $display("FAIL watchdog got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_mem_writer.md
Name: uart_rx_mem_writer

Overview:
- Serial receiver for the matrix_operation datapath. Deserialises 8N1 UART frames on `rx` and writes each byte into the 1024-entry matrix memory at consecutive addresses.
- Emits a one-cycle `done` pulse once DEPTH bytes have been stored. Downstream compute then starts, and the transmitter later reads the result back.
- Complements the existing memory-to-serial transmit path.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per serial bit; legal values are 4 or more.
- DEPTH, 1024, number of bytes per block; the address counter saturates here.
- ADDR_W, 10, address width; DEPTH must not exceed 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- clear  in  1  one-cycle pulse; restarts the block at address 0.
- addr  out  ADDR_W  write address for the byte on `data`.
- data  out  8  received byte.
- we  out  1  one-cycle write strobe; `addr` and `data` are valid while it is high.
- busy  out  1  high while a frame is in progress (all states except IDLE).
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- done  out  1  one-cycle pulse when byte DEPTH-1 is written.
- full  out  1  high after `done` until `clear` or `rst`.

Behaviour:
- Reset (synchronous, while rst=1):
  - State goes to IDLE.
  - addr, data, we, busy, frame_err, done, full all go to 0.
  - Internal write pointer goes to 0; bit and sample counters go to 0.
  - Synchroniser flops load 1.
- Input synchroniser:
  - `rx` passes through two flops to give rx_s, a latency of 2 clk.
  - All decisions use rx_s.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1.
- State machine, with sample counter sc and bit counter bc:
  - IDLE: if rx_s=0 and full=0, go to START with sc=0. While full=1, line activity is ignored.
  - START: when sc = CLKS_PER_BIT/2-1, sample rx_s.
    - rx_s=1 is a glitch: return to IDLE. No error and no write.
    - rx_s=0: sc=0, bc=0, go to DATA.
  - DATA: when sc = CLKS_PER_BIT-1, shift rx_s into shift[7] (right shift), bc++, sc=0.
    - After the 8th sample, go to STOP.
    - Sampling is therefore mid-bit.
  - STOP: when sc = CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1: on the next edge data<=shift, addr<=wptr, we=1 for exactly one cycle, wptr++, go to IDLE.
    - rx_s=1 and wptr = DEPTH-1 at the write: done=1 for the same cycle as we, full<=1, wptr holds at DEPTH-1.
    - rx_s=0: frame_err=1 for one cycle, no write, wptr unchanged, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- Latency: `we` asserts at 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the falling edge of `rx`.
- `data` and `addr` hold their values after `we` until the next write.
- A back-to-back frame whose start bit immediately follows the stop bit is received with no lost byte. IDLE detects the new start on the cycle after the STOP sample.
- clear:
  - Any state goes to IDLE; wptr=0; full=0.
  - Any frame in progress is aborted with no write and no error.
  - If clear and a write fall on the same cycle, clear wins: we=0 and done=0.
- rst has priority over clear.
- Mid-frame reset: the frame is discarded and the block behaves as after power-up.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK}.
  - FRAME_DATA_BITS=8.
  - START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module uart_rx_sync: two-flop synchroniser on `rx` producing rx_s, with reset value 1.
- The FSM, counters and write pointer stay in uart_rx_mem_writer.

Test Plan (all with CLKS_PER_BIT=8):
- Single frame: drive 0xA5 at 8 clk/bit after reset -> one `we` pulse with data=0xA5, addr=0; frame_err=0; busy falls after the stop sample.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap -> three `we` pulses with addr 0, 1, 2 and the matching data. Check the strobe spacing is 80 clk.
- Glitch: a 3-clk low pulse on `rx` -> no `we`, no frame_err; state returns to IDLE; the next valid 0x12 is written at addr 0.
- Framing error: send 0x55 with stop bit 0, then hold rx low 40 clk, then high -> frame_err pulses once; no write; no retrigger; the next 0x66 is written at addr 0.
- Full block: send 1024 bytes with value (i mod 256) -> 1024 `we` pulses with addr 0..1023; `done` coincides with the addr=1023 write; full=1; a 1025th byte is ignored.
- Clear/reset mid-frame: assert clear during bit 4 of a frame -> no write; then 0x77 is written at addr 0 and full=0. Repeat with rst -> all outputs are 0 on the next edge.
